// File: rtl/seg_stream_pkg.sv
// Shared constants for the 7-segment serial stream decoder.
// Patterns are active-low segments g..a (bit6..bit0), indexed by hex value.
package seg_stream_pkg;

    localparam int BITS_PER_DIGIT = 8;
    localparam int DP_BIT         = 7;

    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment map: one received byte -> hex nibble, legality flag, decimal point.
// Illegal patterns (including blank) yield nibble 0 with valid low.
module seg7_to_hex
    import seg_stream_pkg::*;
(
    input  logic [BITS_PER_DIGIT-1:0] i_seg,
    output logic [3:0]                o_nibble,
    output logic                      o_valid,
    output logic                      o_dp
);

    // Patterns are unique, so OR-ing the matches leaves at most one index.
    always_comb begin
        o_nibble = 4'd0;
        o_valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            o_nibble = o_nibble | ({4{i_seg[6:0] == SEG_PATTERN[i]}} & 4'(i));
            o_valid  = o_valid | (i_seg[6:0] == SEG_PATTERN[i]);
        end
        o_dp = ~i_seg[DP_BIT];
    end

endmodule

// File: rtl/seg_stream_decoder.sv
// Deserialises the active-low 8-digit segment stream and decodes each digit back to hex.
// Loopback checker for the display path: synchronisers, edge detect, bit counter, output registers.
module seg_stream_decoder
    import seg_stream_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_seg_clk,
    input  logic                  i_seg_dat,
    input  logic                  i_seg_clr_n,
    output logic [4*DIGITS-1:0]   o_hex_value,
    output logic [DIGITS-1:0]     o_digit_valid,
    output logic [DIGITS-1:0]     o_dp,
    output logic                  o_frame_valid,
    output logic                  o_frame_err
);

    localparam int FRAME_BITS = DIGITS * BITS_PER_DIGIT;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_clr_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;

    // The final frame bit is never stored: it is decoded straight from the synchroniser.
    logic [FRAME_BITS-2:0]  r_shift;
    logic [CNT_W-1:0]       r_cnt;

    logic [4*DIGITS-1:0]    r_hex_value;
    logic [DIGITS-1:0]      r_digit_valid;
    logic [DIGITS-1:0]      r_dp;
    logic                   r_frame_valid;
    logic                   r_frame_err;

    logic                   w_strobe;
    logic                   w_clr;
    logic                   w_bit;
    logic [FRAME_BITS-1:0]  w_frame;
    logic [4*DIGITS-1:0]    w_nibbles;
    logic [DIGITS-1:0]      w_valids;
    logic [DIGITS-1:0]      w_dps;

    // Synchronise seg_clk/seg_clr_n and delay seg_dat identically so it stays aligned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync <= {SYNC_STAGES{1'b0}};
            r_clr_sync <= {SYNC_STAGES{1'b0}};
            r_dat_sync <= {SYNC_STAGES{1'b0}};
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_seg_clk};
            r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], i_seg_clr_n};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_seg_dat};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_strobe = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
    assign w_clr    = ~r_clr_sync[SYNC_STAGES-1];
    assign w_bit    = r_dat_sync[SYNC_STAGES-1];
    assign w_frame  = {r_shift, w_bit};

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_to_hex u_dec (
            .i_seg    (w_frame[g*BITS_PER_DIGIT +: BITS_PER_DIGIT]),
            .o_nibble (w_nibbles[g*4 +: 4]),
            .o_valid  (w_valids[g]),
            .o_dp     (w_dps[g])
        );
    end

    // Frame assembly: clear beats a coincident strobe; the completing strobe loads the outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift       <= {(FRAME_BITS-1){1'b0}};
            r_cnt         <= {CNT_W{1'b0}};
            r_hex_value   <= {(4*DIGITS){1'b0}};
            r_digit_valid <= {DIGITS{1'b0}};
            r_dp          <= {DIGITS{1'b0}};
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_clr) begin
                r_frame_err <= (r_cnt != {CNT_W{1'b0}});
                r_cnt       <= {CNT_W{1'b0}};
                r_shift     <= {(FRAME_BITS-1){1'b0}};
            end else if (w_strobe) begin
                r_shift <= w_frame[FRAME_BITS-2:0];
                if (r_cnt == LAST_CNT) begin
                    r_cnt         <= {CNT_W{1'b0}};
                    r_hex_value   <= w_nibbles;
                    r_digit_valid <= w_valids;
                    r_dp          <= w_dps;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_hex_value   = r_hex_value;
    assign o_digit_valid = r_digit_valid;
    assign o_dp          = r_dp;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_seg_stream_decoder.sv
// Self-checking bench for seg_stream_decoder: directed frames plus randomized frames/aborts
// checked against a table-lookup model of the display encoding.
module tb_seg_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        seg_clk = 1'b0;
    logic        seg_dat = 1'b0;
    logic        seg_clr_n = 1'b1;
    logic [31:0] hex_value;
    logic [7:0]  digit_valid;
    logic [7:0]  dp;
    logic        frame_valid;
    logic        frame_err;

    int n_total = 0;
    int n_bad   = 0;
    int fe_cnt  = 0;
    logic [47:0] fv_q[$];

    logic [31:0] exp_hex = 32'h0;
    logic [7:0]  exp_val = 8'h0;
    logic [7:0]  exp_dp  = 8'h0;

    // Display byte for each hex digit with the decimal point dark (bit7 = 1).
    logic [7:0] legal [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg_stream_decoder #(.DIGITS(8), .SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_seg_clk     (seg_clk),
        .i_seg_dat     (seg_dat),
        .i_seg_clr_n   (seg_clr_n),
        .o_hex_value   (hex_value),
        .o_digit_valid (digit_valid),
        .o_dp          (dp),
        .o_frame_valid (frame_valid),
        .o_frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Record every frame_valid pulse and count frame_err pulses.
    always @(negedge clk) begin
        if (frame_valid) fv_q.push_back({hex_value, digit_valid, dp});
        if (frame_err) fe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [63:0] f, output logic [31:0] h,
                                  output logic [7:0] v, output logic [7:0] d);
        logic [7:0] b;
        h = 32'h0; v = 8'h0; d = 8'h0;
        for (int k = 0; k < 8; k++) begin
            b = f[k*8 +: 8];
            d[k] = (b[7] == 1'b0);
            for (int x = 0; x < 16; x++) begin
                if ({1'b1, b[6:0]} == legal[x]) begin
                    h[k*4 +: 4] = 4'(x);
                    v[k] = 1'b1;
                end
            end
        end
    endfunction

    task automatic send_bits(input logic [63:0] f, input int n);
        @(negedge clk); #2;
        for (int i = 63; i > 63 - n; i--) begin
            seg_dat = f[i];
            #40 seg_clk = 1'b1;
            #40 seg_clk = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "/hex"}, 64'(hex_value), 64'(exp_hex));
        check_eq({tag, "/valid"}, 64'(digit_valid), 64'(exp_val));
        check_eq({tag, "/dp"}, 64'(dp), 64'(exp_dp));
    endtask

    task automatic frame_check(input string tag, input logic [63:0] f);
        int fe0;
        fv_q.delete();
        fe0 = fe_cnt;
        send_bits(f, 64);
        settle();
        model(f, exp_hex, exp_val, exp_dp);
        check_eq({tag, "/pulses"}, 64'(fv_q.size()), 64'd1);
        check_eq({tag, "/err"}, 64'(fe_cnt - fe0), 64'd0);
        if (fv_q.size() > 0)
            check_eq({tag, "/captured"}, 64'(fv_q[0]), 64'({exp_hex, exp_val, exp_dp}));
        check_outputs(tag);
    endtask

    task automatic abort_check(input string tag, input logic [63:0] f, input int n);
        int fe0;
        fv_q.delete();
        fe0 = fe_cnt;
        send_bits(f, n);
        seg_clr_n = 1'b0;
        #40 seg_clr_n = 1'b1;
        #40;
        settle();
        check_eq({tag, "/err"}, 64'(fe_cnt - fe0), 64'd1);
        check_eq({tag, "/pulses"}, 64'(fv_q.size()), 64'd0);
        check_outputs(tag);
    endtask

    function automatic logic [63:0] rand_frame();
        logic [63:0] f;
        logic [7:0]  b;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 255));
            end else begin
                b = legal[$urandom_range(0, 15)];
                b[7] = 1'($urandom_range(0, 1));
            end
            f[k*8 +: 8] = b;
        end
        return f;
    endfunction

    initial begin
        logic [63:0] f1;
        logic [63:0] f2;
        logic [31:0] h1;
        logic [7:0]  v1;
        logic [7:0]  d1;
        int          fe0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", {16'h0, hex_value, digit_valid, dp},  64'h0);
        check_eq("reset_pulses", {62'h0, frame_valid, frame_err}, 64'h0);
        rst_n = 1'b1;
        settle();

        frame_check("value", 64'hF9A4B099_8883C6A1);
        check_eq("value_const", 64'(hex_value), 64'h1234ABCD);
        frame_check("blank_dp", 64'hFFFFFFFF_FFFF40C0);
        check_eq("blank_dp_const", 64'({hex_value, digit_valid, dp}), 64'h00000000_03_02);

        frame_check("restore", 64'hF9A4B099_8883C6A1);
        abort_check("partial20", 64'hF9A4B099_8883C6A1, 20);
        frame_check("zeros", 64'hC0C0C0C0_C0C0C0C0);

        // Two frames back to back with no clear in between.
        f1 = 64'hF9A4B099_8883C6A1;
        f2 = 64'h8E8E8E8E_8E8E8E8E;
        fv_q.delete();
        send_bits(f1, 64);
        send_bits(f2, 64);
        settle();
        model(f1, h1, v1, d1);
        model(f2, exp_hex, exp_val, exp_dp);
        check_eq("stream/pulses", 64'(fv_q.size()), 64'd2);
        if (fv_q.size() == 2) begin
            check_eq("stream/first", 64'(fv_q[0]), 64'({h1, v1, d1}));
            check_eq("stream/second", 64'(fv_q[1]), 64'({exp_hex, exp_val, exp_dp}));
        end
        check_eq("stream_const", 64'(hex_value), 64'hFFFFFFFF);

        // Clear lands in the same cycle as the 64th rising edge.
        fv_q.delete();
        fe0 = fe_cnt;
        send_bits(f1, 63);
        seg_dat = f1[0];
        #40;
        seg_clr_n = 1'b0;
        seg_clk = 1'b1;
        #40 seg_clk = 1'b0;
        #40 seg_clr_n = 1'b1;
        #40;
        settle();
        check_eq("collide/err", 64'(fe_cnt - fe0), 64'd1);
        check_eq("collide/pulses", 64'(fv_q.size()), 64'd0);
        check_outputs("collide");
        frame_check("after_collide", 64'hC6A1_8688_C0F9_A4B0);

        // Reset in the middle of a frame clears outputs at once and loses the partial frame.
        send_bits(64'hF9A4B099_8883C6A1, 30);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("midreset_state", {16'h0, hex_value, digit_valid, dp}, 64'h0);
        check_eq("midreset_pulses", {62'h0, frame_valid, frame_err}, 64'h0);
        #20 rst_n = 1'b1;
        settle();
        frame_check("after_reset", 64'hF9A4B099_8883C6A1);

        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 1)
                abort_check("rand_abort", rand_frame(), $urandom_range(1, 63));
            frame_check("rand_frame", rand_frame());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_stream_decoder.md
Name: seg_stream_decoder

Overview:
- Receiver for the serial segment stream that drives the board's 8-digit, active-low 7-segment display chain.
- Deserialises each 64-bit frame and inverse-maps every segment byte back to a hex nibble.
- Reports per-digit validity and decimal-point state.
- Used as an on-board loopback checker for score and display logic: the recovered value is compared against the value that was meant to be displayed.

Parameters:
- DIGITS, 8, number of digits per frame; frame length is DIGITS*8 bits.
- SYNC_STAGES, 2, synchroniser depth for the seg_clk and seg_clr_n inputs; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 4x the seg_clk rate.
- rst_n  in  1  asynchronous, active-low reset.
- seg_clk  in  1  serial shift clock (asynchronous to clk); data is sampled on its rising edge.
- seg_dat  in  1  serial segment data.
- seg_clr_n  in  1  active-low frame clear / start-of-frame.
- hex_value  out  4*DIGITS  recovered nibbles; digit DIGITS-1 sits in the MSBs.
- digit_valid  out  DIGITS  1 = segment byte matched a legal 0-F pattern.
- dp  out  DIGITS  1 = decimal point lit (bit7 received as 0).
- frame_valid  out  1  one-cycle pulse when new outputs are presented.
- frame_err  out  1  one-cycle pulse when a partial frame is aborted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - Bit counter 0, shift register 0, synchronisers 0.
- Input synchronisation:
  - seg_clk and seg_clr_n pass through SYNC_STAGES flops.
  - seg_dat is delayed by the same number of flops, keeping it aligned with seg_clk.
  - A rising edge is detected as synced seg_clk = 1 with its previous value = 0. This gives one "bit strobe" clk cycle per edge.
- Frame format:
  - Digit DIGITS-1 is sent first.
  - Within each byte, bit7 (dp, active-low) is sent first and bit0 (segment a) last.
  - Segment value 0 = lit.
- Counting:
  - On each bit strobe, seg_dat shifts into the LSB of the 64-bit shift register and the counter increments.
  - On the strobe that completes bit DIGITS*8, the counter wraps to 0. Back-to-back frames need no clear.
- Decode latency:
  - In the clk cycle after the completing strobe, the outputs below update together and frame_valid is high for exactly that cycle:
    - hex_value, digit_valid and dp for every digit.
  - Outputs hold until the next completed frame.
- Legal segment patterns (bit6..bit0):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
- Illegal patterns (including blank 1111111):
  - digit_valid bit = 0 and nibble = 0.
  - dp is still reported.
- Clear handling:
  - Synced seg_clr_n low with counter != 0: frame_err pulses one cycle, counter goes to 0, shift register goes to 0, outputs are unchanged.
  - seg_clr_n low with counter = 0: no error is reported.
  - Clear held low: counter stays 0 and strobes are ignored.
- Simultaneous events:
  - Clear and bit strobe in the same cycle: the clear wins and the bit is discarded.
  - Clear in the same cycle as the completing strobe: the clear wins, no frame_valid, frame_err pulses.
- Reset mid-frame: the partial frame is lost and no pulse is generated.

Decomposition:
- Package seg_stream_pkg holds:
  - the 16-entry legal segment pattern constant array, indexed by hex value;
  - BITS_PER_DIGIT = 8;
  - the DP_BIT = 7 constant.
- Sub-module seg7_to_hex (combinational) maps an 8-bit byte to:
  - nibble[3:0], valid, dp.
  - It is instantiated DIGITS times.
- The top level holds the synchronisers, edge detect, counter, shift register and output registers.

Test Plan:
- Reset check: rst_n low mid-operation -> all outputs 0 immediately. After release, a full frame still decodes correctly.
- Value decode: frame bytes F9 A4 B0 99 88 83 C6 A1 -> one frame_valid pulse, hex_value=0x1234ABCD, digit_valid=0xFF, dp=0x00.
- Blank and decimal point: bytes FF FF FF FF FF FF 40 C0 -> hex_value=0x00000000, digit_valid=0x03, dp=0x02.
- Partial frame: 20 bits sent then seg_clr_n pulsed low -> frame_err pulse, outputs keep previous 0x1234ABCD. A following full frame of 8x C0 -> hex_value=0, digit_valid=0xFF.
- Continuous stream: two 64-bit frames with no clear (value 0x1234ABCD, then 8x 0x8E=F) -> two frame_valid pulses, second hex_value=0xFFFFFFFF.
- Clear collides with the 64th edge -> frame_err=1, no frame_valid, outputs unchanged, counter 0.
